// File: rtl/demux_pkg.sv
// Shared select-decoding helpers for the 4-channel demux and its mux counterpart,
// so both ends resolve a one-hot select identically (lowest set bit wins, zero -> 3).
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0]        ch_idx_t;
    typedef logic [NUM_CH-1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic ch_idx_t sel_to_idx(input sel_t sel);
        ch_idx_t idx;
        idx = ch_idx_t'(NUM_CH - 1);
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = ch_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input sel_t sel);
        return (sel != '0) && ((sel & (sel - sel_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry valid/ready register stage: load, drain and same-cycle pass-through.
// Output visible one cycle after load; holds its beat while the consumer stalls.
module out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] dout
);

    slot_state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            dout  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        dout  <= din;
                    end
                end
                SLOT_FULL: begin
                    // A reload wins over the drain so the channel streams at full rate.
                    if (load) begin
                        dout <= din;
                    end else if (ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1x4.sv
// Streaming 1-to-4 demux routing each beat by one-hot select into a registered slot.
// One-cycle latency; a beat stalls only when its own channel is full and not ready.
module demux_1x4 #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = demux_pkg::NUM_CH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic [NUM_CH-1:0]        in_sel_i,
    output logic [NUM_CH-1:0]        out_valid_o,
    input  logic [NUM_CH-1:0]        out_ready_i,
    output logic [NUM_CH*DATA_W-1:0] out_data_o,
    output logic                     sel_err_o
);

    import demux_pkg::*;

    ch_idx_t ch;
    logic    accept;

    assign ch         = sel_to_idx(in_sel_i);
    assign in_ready_o = ~reset & (~out_valid_o[ch] | out_ready_i[ch]);
    assign accept     = in_valid_i & in_ready_o;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (accept && (ch == ch_idx_t'(k))),
            .din   (in_data_i),
            .ready (out_ready_i[k]),
            .valid (out_valid_o[k]),
            .dout  (out_data_o[k*DATA_W +: DATA_W])
        );
    end

    // Malformed selects are still routed; this only flags them to the consumer side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_o <= 1'b0;
        end else begin
            sel_err_o <= accept & ~is_onehot(in_sel_i);
        end
    end

endmodule

// File: tb/tb_demux_1x4.sv
// Self-checking bench for demux_1x4: directed scenarios plus randomized traffic
// against a per-channel queue scoreboard.
module tb_demux_1x4;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [NUM_CH-1:0]        in_sel;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     sel_err;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mq [NUM_CH][$];
    logic              exp_err;

    demux_1x4 #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_sel_i    (in_sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .sel_err_o   (sel_err)
    );

    always #5 clk = ~clk;

    function automatic int ref_ch(input logic [NUM_CH-1:0] s);
        for (int i = 0; i < NUM_CH; i++) begin
            if (s[i]) return i;
        end
        return 3;
    endfunction

    function automatic logic [DATA_W-1:0] chan(input int k);
        return out_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; out_ready = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_sel = 4'b0001; in_data = 8'h77; out_ready = '1;
        #2;
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_valid got %b want 0000", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", out_data); end
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", sel_err); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", in_ready); end
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_valid_edge got %b want 0000", out_valid); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 4'b0100; out_ready = 4'b1111;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0100) begin miscompares++; $display("FAIL basic_valid got %b want 0100", out_valid); end
        vectors++; if (chan(2) !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h want a5", chan(2)); end
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", sel_err); end
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL basic_drain got %b want 0000", out_valid); end
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL basic_err2 got %b want 0", sel_err); end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b1111;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = DATA_W'(i); in_sel = 4'b0001;
            @(negedge clk);
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready beat %0d got %b want 1", i, in_ready); end
            if (i > 1) begin
                vectors++;
                if (out_valid[0] !== 1'b1 || chan(0) !== DATA_W'(i - 1)) begin
                    miscompares++; $display("FAIL b2b_out beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid[0], chan(0), DATA_W'(i - 1));
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid[0] !== 1'b1 || chan(0) !== 8'h03) begin
            miscompares++; $display("FAIL b2b_last got v=%b d=%h want v=1 d=03", out_valid[0], chan(0));
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        out_ready = 4'b1101; in_valid = 1'b1; in_sel = 4'b0010; in_data = 8'h11;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_first_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_data = 8'h22;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready cyc %0d got %b want 0", c, in_ready); end
            vectors++;
            if (out_valid[1] !== 1'b1 || chan(1) !== 8'h11) begin
                miscompares++; $display("FAIL stall_hold cyc %0d got v=%b d=%h want v=1 d=11", c, out_valid[1], chan(1));
            end
            @(posedge clk); #1;
        end
        out_ready = 4'b1111;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_sel = 4'b1000; in_data = 8'h33;
        @(negedge clk);
        vectors++;
        if (out_valid[1] !== 1'b1 || chan(1) !== 8'h22) begin
            miscompares++; $display("FAIL stall_second got v=%b d=%h want v=1 d=22", out_valid[1], chan(1));
        end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_other_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b1000) begin miscompares++; $display("FAIL stall_other_valid got %b want 1000", out_valid); end
        vectors++; if (chan(3) !== 8'h33) begin miscompares++; $display("FAIL stall_other_data got %h want 33", chan(3)); end
    endtask

    task automatic test_sel_err();
        @(posedge clk); #1;
        out_ready = 4'b1111; in_valid = 1'b1; in_sel = 4'b0110; in_data = 8'h3C;
        @(posedge clk); #1;
        in_sel = 4'b0000; in_data = 8'hC3;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0010 || chan(1) !== 8'h3C) begin miscompares++; $display("FAIL err_multi_route got v=%b d=%h want v=0010 d=3c", out_valid, chan(1)); end
        vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL err_multi_pulse got %b want 1", sel_err); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b1000 || chan(3) !== 8'hC3) begin miscompares++; $display("FAIL err_zero_route got v=%b d=%h want v=1000 d=c3", out_valid, chan(3)); end
        vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL err_zero_pulse got %b want 1", sel_err); end
        @(negedge clk);
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", sel_err); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 4'b0000; in_valid = 1'b1; in_sel = 4'b0001; in_data = 8'hAA;
        @(posedge clk); #1;
        in_sel = 4'b1000; in_data = 8'hBB;
        @(posedge clk); #1;
        in_sel = 4'b0001; in_data = 8'h5A;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b1001) begin miscompares++; $display("FAIL mid_fill got %b want 1001", out_valid); end
        #1;
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL mid_async_valid got %b want 0000", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL mid_async_data got %h want 0", out_data); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready got %b want 0", in_ready); end
        @(negedge clk); #1;
        reset = 1'b0; out_ready = 4'b1111;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_resume_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0001 || chan(0) !== 8'h5A) begin miscompares++; $display("FAIL mid_resume got v=%b d=%h want v=0001 d=5a", out_valid, chan(0)); end
    endtask

    task automatic test_random(input int n);
        bit stalled = 0;
        int c;
        logic exp_rdy;
        do_reset();
        for (int k = 0; k < NUM_CH; k++) mq[k].delete();
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) < 7) in_sel = 4'b0001 << $urandom_range(0, 3);
                else                          in_sel = 4'($urandom_range(0, 15));
                in_data = 8'($urandom);
            end
            for (int k = 0; k < NUM_CH; k++) out_ready[k] = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            c = ref_ch(in_sel);
            exp_rdy = (mq[c].size() == 0) || out_ready[c];
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, exp_rdy); end
            vectors++; if (sel_err !== exp_err) begin miscompares++; $display("FAIL rnd_err cyc %0d got %b want %b", i, sel_err, exp_err); end
            for (int k = 0; k < NUM_CH; k++) begin
                vectors++;
                if (out_valid[k] !== (mq[k].size() != 0)) begin
                    miscompares++; $display("FAIL rnd_valid cyc %0d ch %0d got %b want %b", i, k, out_valid[k], mq[k].size() != 0);
                end else if (mq[k].size() != 0 && chan(k) !== mq[k][0]) begin
                    miscompares++; $display("FAIL rnd_data cyc %0d ch %0d got %h want %h", i, k, chan(k), mq[k][0]);
                end
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
            end
            if (in_valid && exp_rdy) begin
                mq[c].push_back(in_data);
                exp_err = ($countones(in_sel) != 1);
            end else begin
                exp_err = 1'b0;
            end
            stalled = in_valid && !exp_rdy;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_sel_err();
        test_reset_mid();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_1x4.md
# demux_1x4

Streaming 1-to-4 demultiplexer: the write-side counterpart of the team's 4-input one-hot-select mux. Accepts one data beat per cycle on a valid/ready input channel and routes it, by a one-hot select sent with the beat, to one of four registered valid/ready output channels. Select decoding matches the mux exactly:
- lowest set bit wins;
- all-zero select resolves to channel 3.

A mux fed by this block's outputs therefore reconstructs the original stream.

## Interface
Parameters:
- DATA_W, 8, width of one data beat
- NUM_CH, 4, number of output channels (fixed at 4; exposed for package use only)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid_i  input  1  input beat valid
- in_ready_o  output  1  input beat can be accepted this cycle
- in_data_i  input  DATA_W  input beat data
- in_sel_i  input  4  one-hot destination select, qualified by in_valid_i
- out_valid_o  output  4  bit k: channel k holds a beat
- out_ready_i  input  4  bit k: channel k consumer accepts
- out_data_o  output  4*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
- sel_err_o  output  1  one-cycle pulse: accepted beat had a non-one-hot select

## Operation
- Resolved channel ch = index of the lowest set bit of in_sel_i; in_sel_i == 4'b0000 gives ch = 3.
- Each channel has a one-entry output slot with two states:
  - EMPTY → FULL on load;
  - FULL → EMPTY on drain without load;
  - FULL → FULL on simultaneous drain and load.
- in_ready_o = ~reset & (slot[ch] EMPTY | out_ready_i[ch]). It is combinational from in_sel_i, out_ready_i and slot state, with no dependency on in_valid_i.
- Accept = in_valid_i & in_ready_o. On accept, slot[ch] loads in_data_i and goes FULL.
- Drain of channel k = out_valid_o[k] & out_ready_i[k]. This empties slot k unless the same cycle reloads it.
- Non-selected channels drain independently; a stalled channel never blocks beats routed to other channels.
- Head-of-line: a beat targeting a FULL, non-ready channel stalls. in_valid_i, in_data_i and in_sel_i must stay stable until accepted, and in_sel_i may not change while in_valid_i is high and in_ready_o is low.
- sel_err_o pulses on the cycle after an accepted beat whose in_sel_i is not exactly one-hot (zero or multiple bits set). The beat is still routed per the resolution rule.
- out_data_o[k] holds its last value when EMPTY; it is not cleared on drain.

## Timing
- Reset values:
  - out_valid_o = 4'b0000, out_data_o = 0, sel_err_o = 0;
  - in_ready_o = 0 while reset is high;
  - all slots EMPTY.
- Reset asserted mid-operation discards every held beat immediately, without waiting for a clock edge. The first accept is possible in the first cycle after reset deasserts.
- Latency: accept at edge n gives out_valid_o[ch] high after edge n, so the beat is visible in cycle n+1.
- Throughput: 1 beat/cycle sustained to any one channel while its out_ready_i stays high (pass-through on simultaneous drain and load); 1 beat/cycle aggregate across channels.
- out_valid_o and out_data_o are registered outputs. in_ready_o is the only combinational output.
- sel_err_o is registered and high for exactly one cycle per offending accepted beat.

## Structure
- Package demux_pkg:
  - NUM_CH = 4;
  - typedef ch_idx_t (2-bit channel index);
  - function sel_to_idx (lowest-set-bit priority, zero → 3);
  - function is_onehot.
- The same package function is shared with the mux so both ends decode identically.
- Sub-module out_slot holds the one-entry valid/ready register stage (load, drain, pass-through). It is instantiated NUM_CH times via generate.

## Test plan
- Reset release, then send data 8'hA5 with sel 4'b0100, all out_ready_i = 1:
  - out_valid_o = 4'b0100 and channel 2 data = 8'hA5 one cycle after accept;
  - sel_err_o stays 0.
- Back-to-back beats 8'h01, 8'h02, 8'h03 all with sel 4'b0001, out_ready_i[0] = 1:
  - in_ready_o stays high throughout;
  - channel 0 outputs 01, 02, 03 on consecutive cycles.
- out_ready_i[1] = 0, then send two beats to sel 4'b0010:
  - first beat accepted;
  - second beat stalls with in_ready_o = 0;
  - a beat to sel 4'b1000 sent after the stall clears is accepted normally;
  - raising out_ready_i[1] releases the stall.
- Send sel 4'b0110 with data 8'h3C, then sel 4'b0000 with data 8'hC3:
  - 3C appears on channel 1 and C3 on channel 3;
  - sel_err_o pulses once for each beat.
- Fill channels 0 and 3 with out_ready_i = 0, then assert reset for one cycle mid-stream:
  - out_valid_o drops to 0 asynchronously;
  - out_data_o = 0;
  - in_ready_o = 0 during reset;
  - normal acceptance resumes the cycle after deassertion.
